fifo_burst_reader: RTL and testbench

//  Read-side master for the sync FIFO (FIFO_WIDTH x FIFO_DEPTH, registered dout one cycle after rd_en).

---
 rtl/fifo_burst_reader.sv | 137 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side master that drains a sync FIFO into a valid/ready stream in bursts of up to BURST_LEN beats.
// Optional FIFO_RD_STATS_EN adds accepted-beat and accepted-burst counters.
//
// state | meaning
// IDLE  | no burst open, waiting for FIFO data
// READ  | issuing FIFO reads for the current burst
// WAIT  | last read tagged, draining buffered beats to the stream
module fifo_burst_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_almostempty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  err_underflow
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [15:0]           stat_bursts
`endif
);

    localparam int CNT_MAX = (BURST_LEN > FIFO_DEPTH) ? BURST_LEN : FIFO_DEPTH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

    state_t                state;
    logic [CW-1:0]         beat_cnt;
    logic [1:0]            ob_cnt;
    logic                  inflight;
    logic                  inflight_last;
    logic [FIFO_WIDTH-1:0] ob0_data;
    logic [FIFO_WIDTH-1:0] ob1_data;
    logic                  ob0_last;
    logic                  ob1_last;
    logic                  pop;
    logic                  push;
    logic                  space_ok;
    logic                  rd_last;

    assign pop  = m_valid && m_ready;
    assign push = inflight;

    // A beat leaving this cycle frees a slot for a read issued this cycle.
    assign space_ok   = ({1'b0, ob_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign fifo_rd_en = !rst && (state == READ) && !fifo_empty && space_ok;
    assign rd_last    = fifo_almostempty || (beat_cnt == CW'(BURST_LEN - 1));

    assign m_valid = (ob_cnt != 2'd0);
    assign m_data  = ob0_data;
    assign m_last  = ob0_last;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            ob_cnt        <= 2'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            ob0_data      <= '0;
            ob1_data      <= '0;
            ob0_last      <= 1'b0;
            ob1_last      <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_underflow <= err_underflow | fifo_underflow;
            inflight      <= fifo_rd_en;
            if (fifo_rd_en) begin
                inflight_last <= rd_last;
                beat_cnt      <= rd_last ? '0 : beat_cnt + 1'b1;
            end

            // Slot 0 is always the head; slot 1 only fills behind it.
            case ({push, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) begin
                        ob0_data <= fifo_dout;
                        ob0_last <= inflight_last;
                    end else begin
                        ob1_data <= fifo_dout;
                        ob1_last <= inflight_last;
                    end
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b01: begin
                    ob0_data <= ob1_data;
                    ob0_last <= ob1_last;
                    ob_cnt   <= ob_cnt - 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob0_data <= fifo_dout;
                        ob0_last <= inflight_last;
                    end else begin
                        ob0_data <= ob1_data;
                        ob0_last <= ob1_last;
                        ob1_data <= fifo_dout;
                        ob1_last <= inflight_last;
                    end
                end
                default: ;
            endcase

            case (state)
                IDLE:    if (!fifo_empty) state <= READ;
                READ:    if (fifo_rd_en && rd_last) state <= WAIT;
                WAIT:    if (pop && m_last && (ob_cnt == 2'd1) && !inflight) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats  <= '0;
            stat_bursts <= '0;
        end else begin
            stat_beats  <= stat_beats + {31'd0, pop};
            stat_bursts <= stat_bursts + {15'd0, pop && m_last};
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model on the read port, expected stream derived from burst rules.
module tb_fifo_burst_reader;
    localparam int W  = 16;
    localparam int BL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fifo_underflow = 1'b0;
    logic         m_ready = 1'b0;
    logic         fifo_empty, fifo_almostempty, fifo_rd_en;
    logic         m_valid, m_last, busy, err_underflow;
    logic [W-1:0] fifo_dout = '0;
    logic [W-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [31:0]  stat_beats;
    logic [15:0]  stat_bursts;
`endif

    logic [W-1:0] mem [0:255];
    int           rd_ptr = 0;
    int           wr_ptr = 0;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           mode = 0;
    int           acc_cnt = 0;
    int           outstanding = 0;
    int           first_rd_cyc = -1;
    int           first_val_cyc = -1;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    logic [W:0]   exp_q[$];
    int           beat_cyc[$];

    fifo_burst_reader #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .BURST_LEN(BL)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_empty       (fifo_empty),
        .fifo_almostempty (fifo_almostempty),
        .fifo_underflow   (fifo_underflow),
        .fifo_dout        (fifo_dout),
        .fifo_rd_en       (fifo_rd_en),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .busy             (busy),
        .err_underflow    (err_underflow)
`ifdef FIFO_RD_STATS_EN
        ,
        .stat_beats       (stat_beats),
        .stat_bursts      (stat_bursts)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty       = (rd_ptr == wr_ptr);
    assign fifo_almostempty = ((wr_ptr - rd_ptr) == 1);

    always @(posedge clk) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Words enter an empty FIFO with the reader idle, so bursts split every BL words and at the end.
    task automatic preload(input int n, input bit seq);
        logic [W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = seq ? W'(i + 1) : W'($urandom);
            mem[wr_ptr] = d;
            wr_ptr++;
            exp_q.push_back({((i % BL) == BL - 1) || (i == n - 1), d});
        end
    endtask

    task automatic rebuild_expected();
        int n;
        exp_q.delete();
        n = wr_ptr - rd_ptr;
        for (int i = 0; i < n; i++)
            exp_q.push_back({((i % BL) == BL - 1) || (i == n - 1), mem[rd_ptr + i]});
    endtask

    task automatic new_test();
        first_rd_cyc  = -1;
        first_val_cyc = -1;
        acc_cnt       = 0;
        beat_cyc.delete();
    endtask

    task automatic cycle(input logic r, input logic uf);
        logic       accept;
        logic [W:0] e;
        @(negedge clk);
        rst            = r;
        fifo_underflow = uf;
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 2) == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        cyc++;
        if (fifo_rd_en) begin
            chk("rd_en_when_empty", 32'(fifo_empty), 32'd0);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (r) chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
        if (!r && m_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (prev_hold && !r) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
            chk("hold_last", 32'(m_last), 32'(prev_last));
        end
        accept = !r && m_valid && m_ready;
        if (accept) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(m_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(m_data), 32'(e[W-1:0]));
                chk("beat_last", 32'(m_last), 32'(e[W]));
            end
            beat_cyc.push_back(cyc);
            acc_cnt++;
        end
        if (r) begin
            outstanding = 0;
        end else begin
            outstanding += int'(fifo_rd_en) - int'(accept);
            if (fifo_rd_en) chk("outstanding_le2", 32'(outstanding <= 2), 32'd1);
        end
        prev_hold = !r && m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        // Reset with an empty FIFO
        mode = 0;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
`ifdef FIFO_RD_STATS_EN
        chk("rst_stat_beats", stat_beats, 32'd0);
        chk("rst_stat_bursts", 32'(stat_bursts), 32'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_rd_en", 32'(fifo_rd_en), 32'd0);
        end

        // Eight sequential words, always ready: two bursts of four
        new_test();
        preload(8, 1'b1);
        drain("t2");
        chk("t2_latency", 32'(first_val_cyc - first_rd_cyc), 32'd2);
        chk("t2_beats", 32'(beat_cyc.size()), 32'd8);
        for (int i = 0; i < 7; i++)
            if ((i % BL) != BL - 1)
                chk("t2_rate", 32'(beat_cyc[i+1] - beat_cyc[i]), 32'd1);
`ifdef FIFO_RD_STATS_EN
        chk("t2_stat_beats", stat_beats, 32'd8);
        chk("t2_stat_bursts", 32'(stat_bursts), 32'd2);
`endif

        // Short burst ended by almost-empty
        new_test();
        preload(3, 1'b0);
        drain("t3");
        chk("t3_beats", 32'(beat_cyc.size()), 32'd3);

        // Alternating ready
        mode = 1;
        new_test();
        preload(8, 1'b1);
        drain("t4");

        // Random ready, random lengths and data
        mode = 2;
        for (int it = 0; it < 4; it++) begin
            new_test();
            preload($urandom_range(1, 12), 1'b0);
            drain("t5");
        end

        // Reset one cycle after the second beat is accepted
        mode = 0;
        new_test();
        preload(8, 1'b1);
        n = 0;
        while (acc_cnt < 2 && n < 50) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        chk("t6_two_beats", 32'(acc_cnt), 32'd2);
        cycle(1'b1, 1'b0);
        rebuild_expected();
        if (exp_q.size() > 0) chk("t6_restart_word", 32'(exp_q[0][W-1:0]), 32'd5);
        cycle(1'b0, 1'b0);
        chk("t6_valid_after_rst", 32'(m_valid), 32'd0);
        chk("t6_busy_after_rst", 32'(busy), 32'd0);
        drain("t6");

        // Sticky underflow error
        cycle(1'b0, 1'b1);
        chk("t7_err_same_cycle", 32'(err_underflow), 32'd0);
        cycle(1'b0, 1'b0);
        chk("t7_err_set", 32'(err_underflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            chk("t7_err_held", 32'(err_underflow), 32'd1);
        end
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("t7_err_cleared", 32'(err_underflow), 32'd0);
`ifdef FIFO_RD_STATS_EN
        chk("t7_stat_beats_rst", stat_beats, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
